// File: rtl/robot_arm_scheduler.sv
// Round-robin arbiter that shares one robot_arm kinematics core between N_REQ requesters.
// Only one job is outstanding at a time; a missing core result is turned into an error response.
module robot_arm_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ANG_W   = 16,
  parameter int XYZ_W   = 32,
  parameter int TIMEOUT = 1024,
  parameter int ID_W    = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*3*ANG_W-1:0]   i_req_thi,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_core_valid,
  output logic [ANG_W-1:0]           o_core_thi1,
  output logic [ANG_W-1:0]           o_core_thi2,
  output logic [ANG_W-1:0]           o_core_thi3,
  input  logic                       i_core_xyz_valid,
  input  logic [XYZ_W-1:0]           i_core_x,
  input  logic [XYZ_W-1:0]           i_core_y,
  input  logic [XYZ_W-1:0]           i_core_z,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [ID_W-1:0]            o_rsp_id,
  output logic [XYZ_W-1:0]           o_rsp_x,
  output logic [XYZ_W-1:0]           o_rsp_y,
  output logic [XYZ_W-1:0]           o_rsp_z,
  output logic                       o_rsp_err,
  output logic                       o_busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]             state;
  logic [ID_W-1:0]        ptr;
  logic [N_REQ-1:0]       grant_oh;
  logic [ID_W-1:0]        grant_id;
  logic [3*ANG_W-1:0]     grant_thi;
  logic                   req_fire;
  logic                   tmo;
  logic [CNT_W-1:0]       cnt;
  logic [3*ANG_W-1:0]     job_thi_p0;
  logic [ID_W-1:0]        job_id_p0;
  logic [XYZ_W-1:0]       rsp_x_p1;
  logic [XYZ_W-1:0]       rsp_y_p1;
  logic [XYZ_W-1:0]       rsp_z_p1;
  logic                   rsp_err_p1;

  // First valid requester at or above the pointer, wrapping modulo N_REQ.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                               input logic [ID_W-1:0]  start);
    logic [N_REQ-1:0] oh;
    logic             found;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (!found && (r == (int'(start) + k) % N_REQ) && vld[r]) begin
          oh[r] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return oh;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    grant_oh = '0;
    if (state == IDLE && !i_rst) grant_oh = rr_pick(i_req_valid, ptr);
  end

  always_comb begin
    grant_id  = '0;
    grant_thi = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant_oh[r]) begin
        grant_id  = ID_W'(r);
        grant_thi = i_req_thi[r*3*ANG_W +: 3*ANG_W];
      end
    end
  end

  assign req_fire = |(grant_oh & i_req_valid);
  assign tmo      = (cnt == CNT_W'(TIMEOUT - 1));

  // Stage p0: job latched at the request handshake; stage p1: result held for the response channel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      job_thi_p0 <= '0;
      job_id_p0  <= '0;
      rsp_x_p1   <= '0;
      rsp_y_p1   <= '0;
      rsp_z_p1   <= '0;
      rsp_err_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            job_thi_p0 <= grant_thi;
            job_id_p0  <= grant_id;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A result arriving on the timeout cycle still counts as a good result.
          if (i_core_xyz_valid) begin
            rsp_x_p1   <= i_core_x;
            rsp_y_p1   <= i_core_y;
            rsp_z_p1   <= i_core_z;
            rsp_err_p1 <= 1'b0;
            state      <= RESP;
          end else if (tmo) begin
            rsp_x_p1   <= '0;
            rsp_y_p1   <= '0;
            rsp_z_p1   <= '0;
            rsp_err_p1 <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            ptr   <= next_ptr(job_id_p0);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = grant_oh;
  assign o_core_valid = (state == ISSUE);
  assign o_core_thi1  = job_thi_p0[0*ANG_W +: ANG_W];
  assign o_core_thi2  = job_thi_p0[1*ANG_W +: ANG_W];
  assign o_core_thi3  = job_thi_p0[2*ANG_W +: ANG_W];
  assign o_rsp_valid  = (state == RESP);
  assign o_rsp_id     = job_id_p0;
  assign o_rsp_x      = rsp_x_p1;
  assign o_rsp_y      = rsp_y_p1;
  assign o_rsp_z      = rsp_z_p1;
  assign o_rsp_err    = rsp_err_p1;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_robot_arm_scheduler.sv
// Directed bench for robot_arm_scheduler: single job, round-robin, timeout, races,
// back-pressure and reset during an outstanding job.
module tb_robot_arm_scheduler;

  localparam int N_REQ = 4;
  localparam int ANG_W = 16;
  localparam int XYZ_W = 32;
  localparam int TMO   = 16;
  localparam int ID_W  = 3;

  logic                     clk;
  logic                     rst;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*3*ANG_W-1:0] req_thi;
  logic [N_REQ-1:0]         req_ready;
  logic                     core_valid;
  logic [ANG_W-1:0]         core_thi1, core_thi2, core_thi3;
  logic                     core_xyz_valid;
  logic [XYZ_W-1:0]         core_x, core_y, core_z;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [XYZ_W-1:0]         rsp_x, rsp_y, rsp_z;
  logic                     rsp_err;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  robot_arm_scheduler #(
    .N_REQ(N_REQ), .ANG_W(ANG_W), .XYZ_W(XYZ_W), .TIMEOUT(TMO), .ID_W(ID_W)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_thi(req_thi), .o_req_ready(req_ready),
    .o_core_valid(core_valid), .o_core_thi1(core_thi1), .o_core_thi2(core_thi2),
    .o_core_thi3(core_thi3),
    .i_core_xyz_valid(core_xyz_valid), .i_core_x(core_x), .i_core_y(core_y), .i_core_z(core_z),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_x(rsp_x), .o_rsp_y(rsp_y), .o_rsp_z(rsp_z), .o_rsp_err(rsp_err),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_thi = '0; rsp_ready = 1'b0;
    core_xyz_valid = 1'b0; core_x = '0; core_y = '0; core_z = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL reset_core_valid: got %b want 0", core_valid); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({rsp_id, rsp_err, rsp_x, core_thi1} !== '0) begin bad++; $display("FAIL reset_data: got id=%0d err=%b x=%h thi1=%h want 0", rsp_id, rsp_err, rsp_x, core_thi1); end
  endtask

  task automatic test_single();
    req_thi[1*48 +: 48] = {16'h0030, 16'h0020, 16'h0010};
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (core_valid !== 1'b1) begin bad++; $display("FAIL single_issue: got %b want 1", core_valid); end
    total++; if ({core_thi3, core_thi2, core_thi1} !== 48'h0030_0020_0010) begin bad++; $display("FAIL single_thi: got %h want 003000200010", {core_thi3, core_thi2, core_thi1}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({core_valid, rsp_valid} !== 2'b00) begin bad++; $display("FAIL single_wait: got cv=%b rv=%b want 0 0", core_valid, rsp_valid); end
    end
    tick();
    core_xyz_valid = 1'b1; core_x = 32'h11; core_y = 32'h22; core_z = 32'h33;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
    tick();
    core_xyz_valid = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    total++; if (rsp_id !== 3'd1) begin bad++; $display("FAIL single_rsp_id: got %0d want 1", rsp_id); end
    total++; if ({rsp_x, rsp_y, rsp_z} !== {32'h11, 32'h22, 32'h33}) begin bad++; $display("FAIL single_xyz: got %h %h %h want 11 22 33", rsp_x, rsp_y, rsp_z); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", rsp_err); end
    total++; if (core_thi2 !== 16'h0020) begin bad++; $display("FAIL single_thi_hold: got %h want 0020", core_thi2); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL single_accept: got rv=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    int          order [5];
    logic [3:0]  exp_rdy;
    int          g, n_rsp, cyc;
    logic        pend;
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1; tick(); rst = 1'b0;
    for (int r = 0; r < N_REQ; r++) req_thi[r*48 +: 48] = {16'(r), 16'(r), 16'(r)};
    req_valid = 4'b1111; rsp_ready = 1'b1;
    g = 0; n_rsp = 0; cyc = 0; pend = 1'b0;
    while (n_rsp < 5 && cyc < 200) begin
      core_xyz_valid = pend; core_x = 32'(cyc); core_y = 32'h0; core_z = 32'h0;
      #1;
      pend = core_valid;
      total++; if ($onehot0(req_ready) !== 1'b1) begin bad++; $display("FAIL rr_onehot: got %b want at most one bit", req_ready); end
      if (req_ready != 4'b0000 && g < 5) begin
        exp_rdy = 4'b0001 << order[g];
        total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_rdy); end
        g++;
      end
      if (rsp_valid) begin
        total++; if (rsp_id !== 3'(order[n_rsp])) begin bad++; $display("FAIL rr_rsp_id%0d: got %0d want %0d", n_rsp, rsp_id, order[n_rsp]); end
        n_rsp++;
      end
      tick();
      cyc++;
    end
    req_valid = '0; rsp_ready = 1'b0; core_xyz_valid = 1'b0;
    total++; if (n_rsp !== 5) begin bad++; $display("FAIL rr_count: got %0d responses want 5", n_rsp); end
  endtask

  task automatic test_timeout();
    req_thi[2*48 +: 48] = {16'h0003, 16'h0002, 16'h0001};
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL tmo_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (core_valid !== 1'b1) begin bad++; $display("FAIL tmo_issue: got %b want 1", core_valid); end
    for (int n = 1; n <= 16; n++) begin
      tick();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL tmo_early%0d: got %b want 0", n, rsp_valid); end
    end
    tick();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL tmo_rsp_valid: got %b want 1", rsp_valid); end
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", rsp_err); end
    total++; if ({rsp_x, rsp_y, rsp_z} !== 96'h0) begin bad++; $display("FAIL tmo_xyz: got %h %h %h want 0", rsp_x, rsp_y, rsp_z); end
    total++; if (rsp_id !== 3'd2) begin bad++; $display("FAIL tmo_id: got %0d want 2", rsp_id); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    core_xyz_valid = 1'b1; core_x = 32'hDEAD; core_y = 32'hBEEF; core_z = 32'h1;
    tick();
    core_xyz_valid = 1'b0;
    #1;
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL tmo_late_strobe: got rv=%b busy=%b want 0 0", rsp_valid, busy); end
    req_thi[3*48 +: 48] = {16'h0c, 16'h0b, 16'h0a};
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    core_xyz_valid = 1'b1; core_x = 32'h77; core_y = 32'h88; core_z = 32'h99;
    tick();
    core_xyz_valid = 1'b0;
    #1;
    total++; if ({rsp_valid, rsp_err, rsp_id, rsp_x} !== {1'b1, 1'b0, 3'd3, 32'h77}) begin bad++; $display("FAIL tmo_next_job: got rv=%b err=%b id=%0d x=%h want 1 0 3 77", rsp_valid, rsp_err, rsp_id, rsp_x); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    req_thi[0*48 +: 48] = {16'h0f, 16'h0e, 16'h0d};
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    for (int n = 1; n <= 16; n++) tick();
    core_xyz_valid = 1'b1; core_x = 32'hAAAA_0001; core_y = 32'hAAAA_0002; core_z = 32'hAAAA_0003;
    tick();
    core_xyz_valid = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL sim_rsp_valid: got %b want 1", rsp_valid); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL sim_err: got %b want 0", rsp_err); end
    total++; if ({rsp_x, rsp_y, rsp_z} !== {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003}) begin bad++; $display("FAIL sim_xyz: got %h %h %h want aaaa0001 aaaa0002 aaaa0003", rsp_x, rsp_y, rsp_z); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    req_thi[1*48 +: 48] = {16'h0005, 16'h0006, 16'h0007};
    req_valid = 4'b1110;
    tick();
    req_valid = 4'b1100;
    tick();
    core_xyz_valid = 1'b1; core_x = 32'h5151; core_y = 32'h6161; core_z = 32'h7171;
    tick();
    core_xyz_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      total++; if ({rsp_valid, rsp_id, rsp_err, rsp_x, rsp_y, rsp_z} !== {1'b1, 3'd1, 1'b0, 32'h5151, 32'h6161, 32'h7171}) begin
        bad++; $display("FAIL bp_hold%0d: got rv=%b id=%0d err=%b x=%h y=%h z=%h want 1 1 0 5151 6161 7171", c, rsp_valid, rsp_id, rsp_err, rsp_x, rsp_y, rsp_z);
      end
      total++; if ({req_ready, core_valid} !== 5'b0) begin bad++; $display("FAIL bp_quiet%0d: got ready=%b cv=%b want 0000 0", c, req_ready, core_valid); end
      tick();
    end
    req_valid = '0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL bp_release: got rv=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmw_in_wait: got busy=%b want 1", busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    core_xyz_valid = 1'b1; core_x = 32'h1234; core_y = 32'h0; core_z = 32'h0;
    #1;
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL rmw_idle: got rv=%b busy=%b want 0 0", rsp_valid, busy); end
    tick();
    core_xyz_valid = 1'b0;
    #1;
    total++; if ({rsp_valid, busy, rsp_x} !== {2'b00, 32'h0}) begin bad++; $display("FAIL rmw_ignored: got rv=%b busy=%b x=%h want 0 0 0", rsp_valid, busy, rsp_x); end
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmw_ptr: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_back_pressure();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/robot_arm_scheduler.md
Name: robot_arm_scheduler

Overview:
Shares one robot_arm kinematics core between N_REQ requesters, for example several task_12 front-ends or a test sequencer. It accepts joint-angle triples (thi1, thi2, thi3) over per-requester valid/ready, grants them round-robin, and issues exactly one job at a time to the core. It waits for the core's xyz result or a timeout, then returns the result tagged with the requester ID over a valid/ready response channel.

Parameters:
N_REQ, 4, number of requesters (2..8)
ANG_W, 16, width of each joint angle
XYZ_W, 32, width of each x/y/z result
TIMEOUT, 1024, max cycles waited for core result after issue (>=2)
ID_W, 3, requester ID width, >= clog2(N_REQ)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_req_valid  in  N_REQ  per-requester job valid
i_req_thi  in  N_REQ*3*ANG_W  requester r at bits [r*3*ANG_W +: 3*ANG_W]; thi1 in LSBs, then thi2, thi3
o_req_ready  out  N_REQ  per-requester accept, at most one bit set
o_core_valid  out  1  one-cycle job strobe to core (i_thi_valid)
o_core_thi1/2/3  out  ANG_W each  angles to core
i_core_xyz_valid  in  1  core result strobe
i_core_x/y/z  in  XYZ_W each  core result
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response accept
o_rsp_id  out  ID_W  requester index of response
o_rsp_x/y/z  out  XYZ_W each  result (0 on error)
o_rsp_err  out  1  response produced by timeout
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; rr pointer 0; all outputs 0, o_req_ready 0. Any in-flight job is dropped and no response is produced; a late core strobe after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant g = first r with i_req_valid[r]=1, searching from the pointer upward with wrap mod N_REQ. o_req_ready = onehot(g), combinational from i_req_valid and the pointer. It is 0 when no request is valid, and 0 in every other state.
- Handshake on i_req_valid[g] & o_req_ready[g]: latch thi and id=g, go to ISSUE.
- ISSUE, one cycle: o_core_valid=1 with the latched thi. o_core_thi holds its value outside ISSUE. Clear the timeout counter; go to WAIT.
- WAIT: the counter increments each cycle.
  - i_core_xyz_valid=1: capture x/y/z, err=0, go to RESP.
  - Otherwise, counter==TIMEOUT-1: x/y/z=0, err=1, go to RESP.
  - Both in the same cycle: the result wins, err=0.
- i_core_xyz_valid outside WAIT is ignored. A second strobe in WAIT cannot occur, because the first strobe exits WAIT.
- RESP: o_rsp_valid=1. id, x/y/z and err are stable until accepted.
  - Accept on o_rsp_valid & i_rsp_ready: set pointer=(id+1) mod N_REQ, go to IDLE.
  - Back-pressure is unbounded; no timeout applies in RESP.
- Latency: request handshake at cycle t, o_core_valid at t+1. Response valid one cycle after the core strobe. With a core of latency L (strobe at t+1+L), o_rsp_valid rises at t+2+L.
- Minimum spacing between back-to-back grants: accept cycle, then IDLE next cycle.
- Fairness: a requester held continuously valid is granted within N_REQ jobs.
- Requester-side drop of i_req_valid before ready is allowed; no state change.

Test Plan:
- Single job: reset, then req1 valid with thi=(0x0010,0x0020,0x0030), core model latency 5 returning x=0x11,y=0x22,z=0x33 -> o_core_valid 1 cycle after accept with those angles; o_rsp_valid 6 cycles after core strobe-start path (t+7); rsp_id=1, x/y/z match, err=0.
- Round-robin: all 4 requesters valid continuously, i_rsp_ready=1 -> grant order 0,1,2,3,0; o_req_ready never multi-hot.
- Timeout: TIMEOUT=16, core never responds -> o_rsp_valid at 17 cycles after issue with err=1, x/y/z=0. A late core strobe afterwards is ignored and the next grant proceeds normally.
- Simultaneous: core strobe on the exact timeout cycle -> err=0, data captured.
- Back-pressure: hold i_rsp_ready=0 for 50 cycles -> o_rsp_* stable, o_req_ready all 0, no o_core_valid. On release the response is accepted once.
- Reset mid-WAIT: assert i_rst during WAIT, core strobes 2 cycles after reset release -> no o_rsp_valid, state IDLE, pointer 0.
